sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 3: idle wait cycles after the two half-word transfers.
REQ-002 clk  in  1  single clock; every state element updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 wr_en  in  1  write request from MEM stage; held until ready is 1.
REQ-005 rd_en  in  1  read request from MEM stage; held until ready is 1.
REQ-006 address  in  32  byte address from the ALU result.
REQ-007 write_data  in  32  store data (Val_Rm).
REQ-008 read_data  out  32  registered load result.
REQ-009 ready  out  1  0 = freeze the pipeline; 1 = the MEM-stage access is complete or no access is pending.
REQ-010 sram_addr  out  18  half-word address to the external SRAM.
REQ-011 sram_dq_out  out  16  write data to the SRAM.
REQ-012 sram_dq_oe  out  1  drive enable for the data bus.
REQ-013 sram_dq_in  in  16  read data from the SRAM.
REQ-014 sram_we_n  out  1  active-low SRAM write strobe.

Function
REQ-015 States SHALL be IDLE, ACCESS and DONE; a counter cnt runs 0..(1+WAIT_CYCLES) in ACCESS.
REQ-016 In IDLE with wr_en or rd_en high: ready=0 combinationally, request latched (op, address, write_data), next state ACCESS with cnt=0.
REQ-017 In IDLE with no request: ready=1, sram_we_n=1, sram_dq_oe=0.
REQ-018 wr_en and rd_en both high: treated as a write; no read is performed.
REQ-019 Word index = (latched address - 1024) mod 2^32, bits [18:2]; sram_addr = {index, 0} at cnt=0 and {index, 1} at cnt=1.
REQ-020 Write, cnt=0: sram_dq_out=write_data[15:0], sram_dq_oe=1, sram_we_n=0.
REQ-021 Write, cnt=1: sram_dq_out=write_data[31:16], sram_dq_oe=1, sram_we_n=0.
REQ-022 Read: sram_we_n=1 and sram_dq_oe=0 throughout; sram_dq_in captured into read_data[15:0] at the end of cnt=0 and into read_data[31:16] at the end of cnt=1.
REQ-023 cnt=2..(1+WAIT_CYCLES): sram_we_n=1, sram_dq_oe=0, sram_addr holds the high half-word address.
REQ-024 After cnt=1+WAIT_CYCLES: next state DONE.
REQ-025 DONE: ready=1 for exactly one cycle, then IDLE; a request still high in the following IDLE cycle SHALL start a new access.
REQ-026 Latency: request first seen in cycle T gives ready=1 at T+2+WAIT_CYCLES+1 (T+6 at default); ready is 0 from T through T+5.
REQ-027 Once latched, an operation completes unchanged even if wr_en, rd_en, address or write_data change or drop.
REQ-028 read_data SHALL change only on read captures and otherwise hold its value across writes and idle cycles.
REQ-029 sram_we_n SHALL never be 0 while sram_dq_oe is 0.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
REQ-031 With rst=0, ready SHALL be 1.
REQ-032 Reset asserted mid-ACCESS: the operation is abandoned with no further SRAM strobes; the write may be partial.
REQ-033 The first rising clk edge after rst returns to 1 SHALL be treated as IDLE.

Verification
REQ-034 Write: address=1024, write_data=0xDEADBEEF, wr_en held; cycle T+1: sram_addr=0, sram_dq_out=0xBEEF, sram_we_n=0; T+2: sram_addr=1, sram_dq_out=0xDEAD, sram_we_n=0; ready=1 only at T+6.
REQ-035 Read: address=1032, model returns 0x1234 at half-word 4 and 0xABCD at half-word 5; read_data=0xABCD1234 when ready rises at T+6.
REQ-036 Back-to-back: write then read to the same address, each request held until ready; read returns the written word; no request is lost or doubled.
REQ-037 wr_en=rd_en=1 simultaneously: SRAM write strobes occur and read_data is unchanged.
REQ-038 rst pulled low at cnt=2 of a write: sram_we_n=1 and ready=1 immediately; after release, a new read completes in 6 cycles.
REQ-039 Request dropped at cnt=0: the access still finishes; the DONE pulse occurs, then IDLE with ready=1.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges a single-cycle 32-bit MEM-stage access onto a 16-bit external SRAM.
// Each access issues two half-word transfers, then WAIT_CYCLES idle cycles, then a one-cycle ready pulse.
module sram_controller #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int CNT_LAST = 1 + WAIT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_LAST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [16:0]        idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        read_data_q, read_data_d;

    logic               req;
    logic [16:0]        word_idx;
    logic               ready_fsm;
    logic               in_access;
    logic               lo_phase;
    logic               hi_phase;
    logic               drive;
    logic               unused_addr_bits;

    // The SRAM window starts at byte 1024; since 1024 is word-aligned the
    // subtraction only needs to be done on the word-index bits.
    assign word_idx         = address[18:2] - 17'd256;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};
    assign req              = wr_en | rd_en;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        ready_fsm   = 1'b0;

        case (state_q)
            IDLE: begin
                ready_fsm = 1'b1;
                if (req) begin
                    // A simultaneous wr_en/rd_en is resolved as a write.
                    ready_fsm = 1'b0;
                    state_d   = ACCESS;
                    cnt_d     = '0;
                    op_wr_d   = wr_en;
                    idx_d     = word_idx;
                    wdata_d   = write_data;
                end
            end
            ACCESS: begin
                if (!op_wr_q && cnt_q == CNT_W'(0)) begin
                    read_data_d[15:0] = sram_dq_in;
                end
                if (!op_wr_q && cnt_q == CNT_W'(1)) begin
                    read_data_d[31:16] = sram_dq_in;
                end
                if (cnt_q == CNT_W'(CNT_LAST)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready_fsm = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
        end
    end

    // Latched request payload; only observed while in ACCESS, so no reset needed.
    always_ff @(posedge clk) begin
        op_wr_q <= op_wr_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    assign in_access = (state_q == ACCESS);
    assign lo_phase  = (cnt_q == CNT_W'(0));
    assign hi_phase  = (cnt_q == CNT_W'(1));
    assign drive     = in_access & op_wr_q & (lo_phase | hi_phase);

    // Strobe and bus enable share one term so we_n can never fall with oe low.
    assign sram_we_n   = ~drive;
    assign sram_dq_oe  = drive;
    assign sram_dq_out = drive ? (lo_phase ? wdata_q[15:0] : wdata_q[31:16]) : 16'h0000;
    assign sram_addr   = in_access ? {idx_q, ~lo_phase} : 18'h00000;
    assign read_data   = read_data_q;
    assign ready       = ~rst | ready_fsm;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;

    logic [15:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [15:0] pl_data = 16'h0000;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    assign sram_dq_in = sram_dq_oe ? 16'h0000 : mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_dq_out;
            strobes <= strobes + 1;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0;
        address = 32'd1024; write_data = 32'h5555_5555;
        @(negedge clk); @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready); end
        n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b want 1", sram_we_n); end
        n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", sram_dq_oe); end
        n_checks++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
        n_checks++; if (sram_dq_out !== 16'h0) begin n_fail++; $display("FAIL rst_dq_out: got %h want 0", sram_dq_out); end
        n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rst_read_data: got %h want 0", read_data); end
        // Preload half-words 4 and 5 for the read test while held in reset.
        pl_en = 1'b1; pl_addr = 8'd4; pl_data = 16'h1234;
        @(negedge clk);
        pl_addr = 8'd5; pl_data = 16'hABCD;
        @(negedge clk);
        pl_en = 1'b0;
        wr_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", ready); end
        n_checks++; if (strobes !== 0) begin n_fail++; $display("FAIL rst_no_strobe: got %0d want 0", strobes); end
    endtask

    task automatic test_write();
        address = 32'd1024; write_data = 32'hDEAD_BEEF; wr_en = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_T: got %b want 0", ready); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL wr_addr_c1: got %h want 0", sram_addr); end
                n_checks++; if (sram_dq_out !== 16'hBEEF) begin n_fail++; $display("FAIL wr_dq_c1: got %h want beef", sram_dq_out); end
                n_checks++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL wr_we_c1: got %b want 0", sram_we_n); end
                n_checks++; if (sram_dq_oe !== 1'b1) begin n_fail++; $display("FAIL wr_oe_c1: got %b want 1", sram_dq_oe); end
            end else if (c == 2) begin
                n_checks++; if (sram_addr !== 18'd1) begin n_fail++; $display("FAIL wr_addr_c2: got %h want 1", sram_addr); end
                n_checks++; if (sram_dq_out !== 16'hDEAD) begin n_fail++; $display("FAIL wr_dq_c2: got %h want dead", sram_dq_out); end
                n_checks++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL wr_we_c2: got %b want 0", sram_we_n); end
            end else if (c <= 5) begin
                n_checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL wr_wait_bus c%0d: we_n=%b oe=%b want 1/0", c, sram_we_n, sram_dq_oe); end
                n_checks++; if (sram_addr !== 18'd1) begin n_fail++; $display("FAIL wr_wait_addr c%0d: got %h want 1", c, sram_addr); end
            end
            n_checks++; if (ready !== (c == 6)) begin n_fail++; $display("FAIL wr_ready c%0d: got %b want %b", c, ready, (c == 6)); end
        end
        wr_en = 1'b0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1) begin n_fail++; $display("FAIL wr_idle: ready=%b we_n=%b want 1/1", ready, sram_we_n); end
        n_checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin n_fail++; $display("FAIL wr_mem: got %h_%h want dead_beef", mem[1], mem[0]); end
        n_checks++; if (strobes !== 2) begin n_fail++; $display("FAIL wr_strobes: got %0d want 2", strobes); end
        n_checks++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL wr_read_data_hold: got %h want 0", read_data); end
    endtask

    task automatic test_read();
        address = 32'd1032; rd_en = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_T: got %b want 0", ready); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rd_bus c%0d: we_n=%b oe=%b want 1/0", c, sram_we_n, sram_dq_oe); end
            if (c == 1) begin
                n_checks++; if (sram_addr !== 18'd4) begin n_fail++; $display("FAIL rd_addr_c1: got %h want 4", sram_addr); end
            end else if (c == 2) begin
                n_checks++; if (sram_addr !== 18'd5) begin n_fail++; $display("FAIL rd_addr_c2: got %h want 5", sram_addr); end
                n_checks++; if (read_data !== 32'h0000_1234) begin n_fail++; $display("FAIL rd_low_half: got %h want 00001234", read_data); end
            end
            n_checks++; if (ready !== (c == 6)) begin n_fail++; $display("FAIL rd_ready c%0d: got %b want %b", c, ready, (c == 6)); end
        end
        n_checks++; if (read_data !== 32'hABCD_1234) begin n_fail++; $display("FAIL rd_data: got %h want abcd1234", read_data); end
        rd_en = 1'b0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || read_data !== 32'hABCD_1234) begin n_fail++; $display("FAIL rd_idle: ready=%b data=%h want 1/abcd1234", ready, read_data); end
        n_checks++; if (strobes !== 2) begin n_fail++; $display("FAIL rd_no_strobe: got %0d want 2", strobes); end
    endtask

    task automatic test_back_to_back();
        int s0;
        int cyc;
        s0 = strobes;
        address = 32'd1048; write_data = 32'h1357_9BDF; wr_en = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ready !== 1'b1 && cyc < 20);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d want 6", cyc); end
        // Read request appears during DONE, so its first IDLE cycle is one later: 7.
        wr_en = 1'b0; rd_en = 1'b1; write_data = 32'h0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ready !== 1'b1 && cyc < 20);
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d want 7", cyc); end
        n_checks++; if (read_data !== 32'h1357_9BDF) begin n_fail++; $display("FAIL b2b_data: got %h want 13579bdf", read_data); end
        n_checks++; if (strobes - s0 !== 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d want 2", strobes - s0); end
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ready !== 1'b1 || strobes - s0 !== 2) begin n_fail++; $display("FAIL b2b_no_extra: ready=%b strobes=%0d want 1/2", ready, strobes - s0); end
        n_checks++; if (mem[12] !== 16'h9BDF || mem[13] !== 16'h1357) begin n_fail++; $display("FAIL b2b_mem: got %h_%h want 1357_9bdf", mem[13], mem[12]); end
    endtask

    task automatic test_both();
        int s0;
        logic [31:0] rd_before;
        s0 = strobes;
        rd_before = read_data;
        address = 32'd1056; write_data = 32'hCAFE_F00D; wr_en = 1'b1; rd_en = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL both_ready_T: got %b want 0", ready); end
        repeat (6) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL both_done: got %b want 1", ready); end
        n_checks++; if (read_data !== rd_before) begin n_fail++; $display("FAIL both_read_data: got %h want %h", read_data, rd_before); end
        n_checks++; if (mem[16] !== 16'hF00D || mem[17] !== 16'hCAFE) begin n_fail++; $display("FAIL both_mem: got %h_%h want cafe_f00d", mem[17], mem[16]); end
        n_checks++; if (strobes - s0 !== 2) begin n_fail++; $display("FAIL both_strobes: got %0d want 2", strobes - s0); end
        // Request still held after DONE: a second access must start.
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL held_req_idle: got %b want 0", ready); end
        @(negedge clk);
        n_checks++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd16) begin n_fail++; $display("FAIL held_req_start: we_n=%b addr=%h want 0/10", sram_we_n, sram_addr); end
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL held_req_done: got %b want 1", ready); end
        n_checks++; if (strobes - s0 !== 4 || read_data !== rd_before) begin n_fail++; $display("FAIL held_req_effects: strobes=%0d data=%h want 4/%h", strobes - s0, read_data, rd_before); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int s0;
        address = 32'd1064; write_data = 32'h1111_2222; wr_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        n_checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bus: we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
        n_checks++; if (sram_addr !== 18'h0 || read_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_regs: addr=%h data=%h want 0/0", sram_addr, read_data); end
        s0 = strobes;
        @(negedge clk);
        n_checks++; if (strobes !== s0) begin n_fail++; $display("FAIL mid_rst_strobes: got %0d want %0d", strobes, s0); end
        rst = 1'b1; address = 32'd1032; rd_en = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_ready_T: got %b want 0", ready); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++; if (ready !== (c == 6)) begin n_fail++; $display("FAIL post_rst_ready c%0d: got %b want %b", c, ready, (c == 6)); end
        end
        n_checks++; if (read_data !== 32'hABCD_1234) begin n_fail++; $display("FAIL post_rst_data: got %h want abcd1234", read_data); end
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop();
        address = 32'd1048; rd_en = 1'b1;
        @(negedge clk);
        n_checks++; if (sram_addr !== 18'd12) begin n_fail++; $display("FAIL drop_addr_c1: got %h want c", sram_addr); end
        rd_en = 1'b0; address = 32'h0; write_data = 32'hFFFF_FFFF;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_checks++; if (sram_addr !== 18'd13) begin n_fail++; $display("FAIL drop_addr_c2: got %h want d", sram_addr); end
            end
            n_checks++; if (ready !== (c == 6)) begin n_fail++; $display("FAIL drop_ready c%0d: got %b want %b", c, ready, (c == 6)); end
        end
        n_checks++; if (read_data !== 32'h1357_9BDF) begin n_fail++; $display("FAIL drop_data: got %h want 13579bdf", read_data); end
        repeat (2) @(negedge clk);
        n_checks++; if (ready !== 1'b1 || sram_addr !== 18'h0 || sram_we_n !== 1'b1) begin n_fail++; $display("FAIL drop_idle: ready=%b addr=%h we_n=%b want 1/0/1", ready, sram_addr, sram_we_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_both();
        test_reset_mid();
        test_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
